// File: rtl/spi_master_engine.sv
// SPI master shift engine: pops one TX word per start request, shifts it out, pushes the RX word.
// Optional build macro SPI_LOOPBACK_EN: latched control bit 4 routes internal MOSI to the sample input.
module spi_master_engine #(
    parameter int unsigned SS_W   = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [31:0]       reg_control_i,
    input  logic [31:0]       reg_trans_ctrl_i,
    output logic              trans_start_o,
    output logic              spi_busy_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_empty_i,
    output logic              tx_rd_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_wr_o,
    input  logic              rx_full_i,
    output logic              rx_ovf_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic [SS_W-1:0]   ss_n_o
);
    localparam int unsigned IW = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, SHIFT, TAIL} state_e;

    state_e            state_q, state_d;
    logic [3:0]        dly_q, dly_d, cnt_q, cnt_d;
    logic              msb_q, msb_d, cpha_q, cpha_d;
    logic [1:0]        wsel_q, wsel_d;
    logic [SS_W-1:0]   en_q, en_d, ss_q, ss_d;
    logic [6:0]        edge_q, edge_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rxd_q, rxd_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d, busy_q, busy_d;
    logic              ts_q, ts_d, rd_q, rd_d, wr_q, wr_d, ovf_q, ovf_d;
`ifdef SPI_LOOPBACK_EN
    logic              lb_q, lb_d;
`endif

    logic [DATA_W-1:0] mask, src, src_sh;
    logic [IW-1:0]     top;
    logic [6:0]        last_edge;
    logic              cur_bit, samp;
    logic              unused_bits;

    // Word-width helpers; in CAPTURE the source is the freshly popped FIFO word.
    always_comb begin
        case (wsel_q)
            2'b00: begin
                mask      = DATA_W'(32'h0000_00FF);
                top       = IW'(7);
                last_edge = 7'd15;
            end
            2'b01: begin
                mask      = DATA_W'(32'h0000_FFFF);
                top       = IW'(15);
                last_edge = 7'd31;
            end
            default: begin
                mask      = '1;
                top       = IW'(31);
                last_edge = 7'd63;
            end
        endcase
        src     = (state_q == CAPTURE) ? (tx_data_i & mask) : tx_q;
        cur_bit = msb_q ? src[top] : src[0];
        src_sh  = msb_q ? (src << 1) : (src >> 1);
`ifdef SPI_LOOPBACK_EN
        samp    = lb_q ? mosi_q : miso_i;
`else
        samp    = miso_i;
`endif
        unused_bits = ^{reg_control_i, reg_trans_ctrl_i};
    end

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        cnt_d   = cnt_q;
        msb_d   = msb_q;
        cpha_d  = cpha_q;
        wsel_d  = wsel_q;
        en_d    = en_q;
        ss_d    = ss_q;
        edge_d  = edge_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rxd_d   = rxd_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        ts_d    = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        ovf_d   = 1'b0;
`ifdef SPI_LOOPBACK_EN
        lb_d    = lb_q;
`endif
        case (state_q)
            IDLE: begin
                sclk_d = reg_control_i[9];
                // Skip the cycle after a start pulse or push so a not-yet-cleared start bit is not re-taken.
                if (reg_trans_ctrl_i[13] && !tx_empty_i && !ts_q && !wr_q && !ovf_q) begin
                    ts_d = 1'b1;
                    if (reg_trans_ctrl_i[6:5] != 2'b11) begin
                        rd_d    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = LOAD;
                        dly_d   = (reg_control_i[3:0] == 4'd0) ? 4'd0 : reg_control_i[3:0] - 4'd1;
                        msb_d   = reg_control_i[8];
                        cpha_d  = reg_control_i[10];
                        wsel_d  = reg_trans_ctrl_i[6:5];
                        en_d    = reg_trans_ctrl_i[SS_W-1:0];
`ifdef SPI_LOOPBACK_EN
                        lb_d    = reg_control_i[4];
`endif
                    end
                end
            end
            LOAD: state_d = CAPTURE;
            CAPTURE: begin
                ss_d    = ~en_q;
                cnt_d   = dly_q;
                edge_d  = '0;
                rx_d    = '0;
                state_d = SHIFT;
                if (!cpha_q) begin
                    mosi_d = cur_bit;
                    tx_d   = src_sh;
                end else begin
                    tx_d   = src;
                end
            end
            SHIFT: begin
                if (cnt_q == 4'd0) begin
                    cnt_d  = dly_q;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 7'd1;
                    // Even edge count before this edge means a leading edge.
                    if (!edge_q[0] ^ cpha_q) begin
                        if (msb_q) begin
                            rx_d = {rx_q[DATA_W-2:0], samp};
                        end else begin
                            rx_d      = rx_q >> 1;
                            rx_d[top] = samp;
                        end
                    end else begin
                        mosi_d = cur_bit;
                        tx_d   = src_sh;
                    end
                    if (edge_q == last_edge) state_d = TAIL;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            TAIL: begin
                if (cnt_q == 4'd0) begin
                    ss_d    = '1;
                    busy_d  = 1'b0;
                    rxd_d   = rx_q & mask;
                    wr_d    = !rx_full_i;
                    ovf_d   = rx_full_i;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            dly_q   <= '0;
            cnt_q   <= '0;
            msb_q   <= 1'b0;
            cpha_q  <= 1'b0;
            wsel_q  <= '0;
            en_q    <= '0;
            ss_q    <= '1;
            edge_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rxd_q   <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            ts_q    <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SPI_LOOPBACK_EN
            lb_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            msb_q   <= msb_d;
            cpha_q  <= cpha_d;
            wsel_q  <= wsel_d;
            en_q    <= en_d;
            ss_q    <= ss_d;
            edge_q  <= edge_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rxd_q   <= rxd_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            ts_q    <= ts_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ovf_q   <= ovf_d;
`ifdef SPI_LOOPBACK_EN
            lb_q    <= lb_d;
`endif
        end
    end

    assign trans_start_o = ts_q;
    assign spi_busy_o    = busy_q;
    assign tx_rd_o       = rd_q;
    assign rx_data_o     = rxd_q;
    assign rx_wr_o       = wr_q;
    assign rx_ovf_o      = ovf_q;
    assign sclk_o        = sclk_q;
    assign mosi_o        = mosi_q;
    assign ss_n_o        = ss_q;

endmodule
